// File: rtl/divsqrt_ctrl.sv
// Sequencing controller for an iterative radix-2 divide / square-root datapath.
// Optional macro DIVSQRT_EARLY_TERM_EN: leave the iteration loop early when the partial remainder is zero.
module divsqrt_ctrl #(
  parameter int DIV_ITERS  = 26,
  parameter int SQRT_ITERS = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       special,
  input  logic       flush,
  input  logic       rem_zero,
  output logic       ready,
  output logic       init_load,
  output logic       iter_en,
  output logic       round_en,
  output logic       done,
  output logic [1:0] op_q,
  output logic [4:0] iter_cnt
);

  // Host handshake: start is a request qualified by ready; a start seen while
  // ready=1 with a legal op is accepted on that edge, anything else is dropped.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ITER  = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   special_q;
  logic   accept;
  logic   early_term;

  assign accept = (state == S_IDLE) && start && !op[1];

`ifdef DIVSQRT_EARLY_TERM_EN
  assign early_term = rem_zero;
`else
  logic unused_rem_zero;
  assign unused_rem_zero = rem_zero;
  assign early_term      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // op_q/special_q only change on accept, so they stay stable for the whole operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= 2'b00;
      special_q <= 1'b0;
      iter_cnt  <= 5'd0;
    end else begin
      if (accept) begin
        op_q      <= op;
        special_q <= special;
      end
      if (state == S_LOAD && !flush) begin
        iter_cnt <= (op_q == 2'b01) ? 5'(SQRT_ITERS) : 5'(DIV_ITERS);
      end else if (state == S_ITER && !flush && !early_term) begin
        iter_cnt <= iter_cnt - 5'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_LOAD;
      S_LOAD: begin
        if (flush)          state_nxt = S_IDLE;
        else if (special_q) state_nxt = S_DONE;
        else                state_nxt = S_ITER;
      end
      S_ITER: begin
        if (flush)                                state_nxt = S_IDLE;
        else if (early_term || iter_cnt <= 5'd1)  state_nxt = S_ROUND;
      end
      S_ROUND: state_nxt = flush ? S_IDLE : S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs decoded from state; the strobes are one-hot by construction.
  always_comb begin
    ready     = 1'b0;
    init_load = 1'b0;
    iter_en   = 1'b0;
    round_en  = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:  ready     = 1'b1;
      S_LOAD:  init_load = 1'b1;
      S_ITER:  iter_en   = 1'b1;
      S_ROUND: round_en  = 1'b1;
      S_DONE:  done      = 1'b1;
      default: ready     = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_divsqrt_ctrl.sv
// Directed bench for divsqrt_ctrl: cycle-accurate latency, bypass, flush, reset and ignore cases.
module tb_divsqrt_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic       special = 1'b0;
  logic       flush = 1'b0;
  logic       rem_zero = 1'b0;
  logic       ready, init_load, iter_en, round_en, done;
  logic [1:0] op_q;
  logic [4:0] iter_cnt;

  int checks = 0;
  int errors = 0;

  // Per-operation observations, measured in cycles after the accepting edge.
  int load_cyc, first_iter, last_iter, iter_n, first_cnt;
  int round_cyc, round_n, round_cnt, done_cyc, done_n;
  int viol, opq_bad, ready_after;

  divsqrt_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .special(special),
    .flush(flush), .rem_zero(rem_zero), .ready(ready), .init_load(init_load),
    .iter_en(iter_en), .round_en(round_en), .done(done), .op_q(op_q),
    .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a sample point (#1 after an edge) while idle; start is taken at the next edge.
  task automatic run_op(input logic [1:0] o, input logic sp, input logic hold,
                        input int flush_at, input int rz_at);
    load_cyc = 0; first_iter = 0; last_iter = 0; iter_n = 0; first_cnt = -1;
    round_cyc = 0; round_n = 0; round_cnt = -1; done_cyc = 0; done_n = 0;
    viol = 0; opq_bad = 0; ready_after = -1;
    start = 1'b1; op = o; special = sp; rem_zero = 1'b0; flush = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      start    = hold && (c < 20);
      op       = hold ? 2'b01 : o;
      special  = 1'b0;
      flush    = (c == flush_at);
      rem_zero = (c == rz_at);
      if ($countones({init_load, iter_en, round_en, done}) > 1) viol++;
      if (!ready && op_q !== o) opq_bad++;
      if (init_load && load_cyc == 0) load_cyc = c;
      if (iter_en) begin
        iter_n++;
        if (first_iter == 0) begin
          first_iter = c;
          first_cnt  = iter_cnt;
        end
        last_iter = c;
      end
      if (round_en) begin
        round_n++;
        round_cyc = c;
        round_cnt = iter_cnt;
      end
      if (done) begin
        done_n++;
        done_cyc = c;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0; rem_zero = 1'b0;
        ready_after = ready;
        break;
      end
      if (flush_at > 0 && c == flush_at + 1) ready_after = ready;
      if (flush_at > 0 && c == flush_at + 2) break;
    end
    start = 1'b0; flush = 1'b0; rem_zero = 1'b0; special = 1'b0; op = 2'b00;
  endtask

  initial begin
    // Reset asserted between edges; outputs must take reset values at once.
    #2 reset = 1'b0;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_init_load", init_load, 0);
    chk("rst_iter_en", iter_en, 0);
    chk("rst_round_en", round_en, 0);
    chk("rst_done", done, 0);
    chk("rst_op_q", op_q, 0);
    chk("rst_iter_cnt", iter_cnt, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;

    // Divide: LOAD 1, ITER 2..27, ROUND 28, DONE 29.
    run_op(2'b00, 1'b0, 1'b0, 0, 0);
    chk("div_load_cyc", load_cyc, 1);
    chk("div_first_iter", first_iter, 2);
    chk("div_last_iter", last_iter, 27);
    chk("div_iter_n", iter_n, 26);
    chk("div_first_cnt", first_cnt, 26);
    chk("div_round_cyc", round_cyc, 28);
    chk("div_round_cnt", round_cnt, 0);
    chk("div_done_cyc", done_cyc, 29);
    chk("div_done_n", done_n, 1);
    chk("div_onehot", viol, 0);
    chk("div_op_q", opq_bad, 0);
    chk("div_ready_after", ready_after, 1);

    // Sqrt, started on the cycle right after the previous done.
    run_op(2'b01, 1'b0, 1'b0, 0, 0);
    chk("sqrt_iter_n", iter_n, 25);
    chk("sqrt_first_cnt", first_cnt, 25);
    chk("sqrt_last_iter", last_iter, 26);
    chk("sqrt_round_cyc", round_cyc, 27);
    chk("sqrt_done_cyc", done_cyc, 28);
    chk("sqrt_op_q", opq_bad, 0);
    chk("sqrt_onehot", viol, 0);

    // Special operand: bypass straight from LOAD to DONE.
    run_op(2'b00, 1'b1, 1'b0, 0, 0);
    chk("spec_load_cyc", load_cyc, 1);
    chk("spec_done_cyc", done_cyc, 2);
    chk("spec_iter_n", iter_n, 0);
    chk("spec_round_n", round_n, 0);
    chk("spec_ready_after", ready_after, 1);

    // Flush during the 10th iteration (cycle 11): idle in cycle 12, no done.
    run_op(2'b00, 1'b0, 1'b0, 11, 0);
    chk("flush_iter_n", iter_n, 10);
    chk("flush_done_n", done_n, 0);
    chk("flush_round_n", round_n, 0);
    chk("flush_ready", ready_after, 1);
    run_op(2'b00, 1'b0, 1'b0, 0, 0);
    chk("post_flush_done_cyc", done_cyc, 29);
    chk("post_flush_iter_n", iter_n, 26);

    // Start held high with op=01 while busy: must not disturb the divide.
    run_op(2'b00, 1'b0, 1'b1, 0, 0);
    chk("busy_done_cyc", done_cyc, 29);
    chk("busy_op_q", opq_bad, 0);
    chk("busy_iter_n", iter_n, 26);

    // Reserved op=11 in IDLE is ignored.
    start = 1'b1; op = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("op11_ready", ready, 1);
      chk("op11_init_load", init_load, 0);
    end
    start = 1'b0; op = 2'b00;

    // Reset mid-ITER, asserted between edges.
    start = 1'b1; op = 2'b01;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    chk("mid_iter_en", iter_en, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_iter_en", iter_en, 0);
    chk("mid_rst_op_q", op_q, 0);
    chk("mid_rst_iter_cnt", iter_cnt, 0);
    chk("mid_rst_done", done, 0);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_idle", ready, 1);
    run_op(2'b00, 1'b0, 1'b0, 0, 0);
    chk("post_rst_done_cyc", done_cyc, 29);
    chk("post_rst_iter_n", iter_n, 26);

    // rem_zero in ITER cycle 5 of a divide.
    run_op(2'b00, 1'b0, 1'b0, 0, 5);
`ifdef DIVSQRT_EARLY_TERM_EN
    chk("rz_round_cyc", round_cyc, 6);
    chk("rz_done_cyc", done_cyc, 7);
    chk("rz_round_cnt", round_cnt, 23);
`else
    chk("rz_round_cyc", round_cyc, 28);
    chk("rz_done_cyc", done_cyc, 29);
    chk("rz_iter_n", iter_n, 26);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
